// File: rtl/imm_encoder.sv
// RV32I immediate encoder: scatters an immediate into a base instruction word, flags
// unrepresentable values, and streams words to instruction memory. Optional: IMM_ENC_ERR_DROP_EN.
module imm_encoder #(
    parameter int                    INSTR_WIDTH   = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR    = '0,
    parameter int                    ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [1:0]               immSrc,
    input  logic                     jumpSrc,
    input  logic [DATA_WIDTH-1:0]    immValue,
    input  logic [INSTR_WIDTH-1:0]   baseInstr,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [INSTR_WIDTH-1:0]   instruction,
    output logic [ADDR_WIDTH-1:0]    writeAddr,
    output logic                     rangeErr,
    input  logic                     addrLoad,
    input  logic [ADDR_WIDTH-1:0]    addrLoadValue,
    output logic [ERR_CNT_WIDTH-1:0] errCount
);

    localparam logic [1:0] SRC_I = 2'b00;
    localparam logic [1:0] SRC_S = 2'b01;
    localparam logic [1:0] SRC_B = 2'b10;

`ifdef IMM_ENC_ERR_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    function automatic logic [INSTR_WIDTH-1:0] encode_imm(
        input logic [INSTR_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0]  imm,
        input logic [1:0]             src,
        input logic                   jmp
    );
        logic [INSTR_WIDTH-1:0] w;
        w = base;
        case (src)
            SRC_I: w[31:20] = imm[11:0];
            SRC_S: begin
                w[31:25] = imm[11:5];
                w[11:7]  = imm[4:0];
            end
            SRC_B: begin
                w[31]    = imm[12];
                w[7]     = imm[11];
                w[30:25] = imm[10:5];
                w[11:8]  = imm[4:1];
            end
            default: begin
                if (jmp) begin
                    w[31:12] = imm[31:12];
                end else begin
                    w[31]    = imm[20];
                    w[30:21] = imm[10:1];
                    w[20]    = imm[11];
                    w[19:12] = imm[19:12];
                end
            end
        endcase
        return w;
    endfunction

    // A field is representable when every bit above the encoded sign bit copies it.
    function automatic logic imm_in_range(
        input logic [DATA_WIDTH-1:0] imm,
        input logic [1:0]            src,
        input logic                  jmp
    );
        logic ok;
        case (src)
            SRC_I, SRC_S: ok = (&imm[31:11]) || !(|imm[31:11]);
            SRC_B:        ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            default: begin
                if (jmp) ok = !(|imm[11:0]);
                else     ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            end
        endcase
        return ok;
    endfunction

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                     adv_p1, adv_p2, out_hs, err_cnt_inc;
    logic [INSTR_WIDTH-1:0]   enc_ins;
    logic                     enc_err;
    logic                     vld_p1_q, err_p1_q;
    logic [INSTR_WIDTH-1:0]   ins_p1_q;
    logic                     vld_p2_q, err_p2_q;
    logic [INSTR_WIDTH-1:0]   ins_p2_q;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [ERR_CNT_WIDTH-1:0] errcnt_q, errcnt_d;

    assign enc_ins = encode_imm(baseInstr, immValue, immSrc, jumpSrc);
    assign enc_err = !imm_in_range(immValue, immSrc, jumpSrc);

    assign adv_p2  = !vld_p2_q || outReady;
    assign adv_p1  = !vld_p1_q || adv_p2;
    assign inReady = adv_p1;
    assign out_hs  = vld_p2_q && outReady;

    assign err_cnt_inc = DROP ? (vld_p1_q && adv_p2 && err_p1_q) : (out_hs && err_p2_q);

    always_comb begin
        addr_d   = addr_q;
        errcnt_d = errcnt_q;
        if (addrLoad)    addr_d = addrLoadValue & ~ADDR_WIDTH'(3);
        else if (out_hs) addr_d = addr_q + ADDR_WIDTH'(4);
        if (err_cnt_inc) errcnt_d = sat_inc(errcnt_q);
    end

    // Stage 1: encoded word and range flag captured on input handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      vld_p1_q <= 1'b0;
        else if (adv_p1) vld_p1_q <= inValid;
    end

    always_ff @(posedge clk) begin
        if (adv_p1 && inValid) begin
            ins_p1_q <= enc_ins;
            err_p1_q <= enc_err;
        end
    end

    // Stage 2: output register, held while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q <= 1'b0;
            ins_p2_q <= '0;
            err_p2_q <= 1'b0;
            addr_q   <= RESET_ADDR;
            errcnt_q <= '0;
        end else begin
            if (adv_p2) begin
                vld_p2_q <= vld_p1_q && !(DROP && err_p1_q);
                if (vld_p1_q) begin
                    ins_p2_q <= ins_p1_q;
                    err_p2_q <= err_p1_q && !DROP;
                end
            end
            addr_q   <= addr_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign outValid    = vld_p2_q;
    assign instruction = ins_p2_q;
    assign rangeErr    = err_p2_q;
    assign writeAddr   = addr_q;
    assign errCount    = errcnt_q;

endmodule
